// File: rtl/pll_pkg.sv
// Shared PLL definitions: divider width, minimum legal ratio and the
// high-phase length helper used by the feedback divider.
package pll_pkg;

  localparam int PLL_DIV_W    = 8;
  localparam int PLL_DIV_NMIN = 2;

  typedef logic [PLL_DIV_W-1:0] pll_div_t;

  // Number of cycles fbclk stays high in an N-cycle period; odd N rounds up.
  function automatic int unsigned pll_div_high(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/pll_fb_divider_if.sv
// Ratio load/ack handshake plus divided-clock status between the loop
// controller (master) and the feedback divider (slave).
interface pll_fb_divider_if #(
  parameter int W = 8
);
  logic [W-1:0] div_n;
  logic         div_load;
  logic         div_ack;
  logic         div_err;
  logic         fbclk;
  logic         tc;
  logic [W-1:0] cnt;

  modport master (
    output div_n, div_load,
    input  div_ack, div_err, fbclk, tc, cnt
  );

  modport slave (
    input  div_n, div_load,
    output div_ack, div_err, fbclk, tc, cnt
  );
endinterface

// File: rtl/pll_div_ratio_ctrl.sv
// Holds the pending ratio, rejects ratios below the minimum, and hands the
// pending value to the counter at its wrap point.
module pll_div_ratio_ctrl
  import pll_pkg::*;
#(
  parameter int W = PLL_DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] div_n,
  input  logic         div_load,
  input  logic         wrap,
  output logic [W-1:0] pend_n,
  output logic         pend_v,
  output logic         apply,
  output logic         div_ack,
  output logic         div_err
);

  logic load_ok;
  logic load_bad;

  always_comb begin
    load_ok  = div_load && (div_n >= W'(PLL_DIV_NMIN));
    load_bad = div_load && (div_n <  W'(PLL_DIV_NMIN));
    apply    = wrap && pend_v;
  end

  // A load coinciding with wrap must survive the clear of the value just applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v  <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_ack <= apply;
      div_err <= load_bad;
      if (load_ok) begin
        pend_v <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok) begin
      pend_n <= div_n;
    end
  end

endmodule

// File: rtl/pll_fb_divider.sv
// Programmable integer feedback divider: counts finalclk cycles modulo the
// active ratio and drives a registered, glitch-free fbclk to the PFD.
module pll_fb_divider
  import pll_pkg::*;
#(
  parameter int W       = PLL_DIV_W,
  parameter int N_RESET = 4
) (
  input  logic              finalclk,
  input  logic              rst,
  pll_fb_divider_if.slave   bus
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] n_act;
  logic [W-1:0] cnt_next;
  logic [W-1:0] n_eff;
  logic [W-1:0] h_eff;
  logic [W-1:0] pend_n;
  logic         pend_v;
  logic         apply;
  logic         wrap;
  logic         fbclk_r;
  logic         tc_r;
  logic         div_ack;
  logic         div_err;

  pll_div_ratio_ctrl #(.W(W)) u_ratio_ctrl (
    .clk      (finalclk),
    .rst      (rst),
    .div_n    (bus.div_n),
    .div_load (bus.div_load),
    .wrap     (wrap),
    .pend_n   (pend_n),
    .pend_v   (pend_v),
    .apply    (apply),
    .div_ack  (div_ack),
    .div_err  (div_err)
  );

  // fbclk is computed from the ratio in force next cycle so a switch lands cleanly.
  always_comb begin
    wrap     = (cnt_r == n_act - W'(1));
    cnt_next = wrap ? '0 : cnt_r + W'(1);
    n_eff    = apply ? pend_n : n_act;
    h_eff    = W'(pll_div_high(32'(n_eff)));
  end

  always_ff @(posedge finalclk) begin
    if (rst) begin
      cnt_r   <= '0;
      n_act   <= W'(N_RESET);
      fbclk_r <= 1'b0;
      tc_r    <= 1'b0;
    end else begin
      cnt_r   <= cnt_next;
      fbclk_r <= (cnt_next < h_eff);
      tc_r    <= wrap;
      if (apply) begin
        n_act <= pend_n;
      end
    end
  end

  assign bus.cnt     = cnt_r;
  assign bus.fbclk   = fbclk_r;
  assign bus.tc      = tc_r;
  assign bus.div_ack = div_ack;
  assign bus.div_err = div_err;

endmodule

// File: tb/tb_pll_fb_divider.sv
// Directed bench for pll_fb_divider: default ratio, odd/even loads, rejected
// loads, last-load-wins, load on wrap and reset with a pending ratio.
module tb_pll_fb_divider;
  localparam int W = 8;

  logic finalclk = 1'b0;
  logic rst      = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pll_fb_divider_if #(.W(W)) bus ();

  pll_fb_divider #(.W(W), .N_RESET(4)) dut (
    .finalclk (finalclk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 finalclk = ~finalclk;

  task automatic tick();
    @(posedge finalclk);
    #1;
  endtask

  // Expected {cnt, fbclk, tc, div_ack, div_err} for a post-reset cycle at
  // phase c of an n-cycle period.
  function automatic logic [11:0] ev(input int c, input int n, input bit ack, input bit err);
    logic [7:0] cv;
    cv = 8'(c);
    return {cv, (c < (n + 1) / 2), (c == 0), ack, err};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.cnt, bus.fbclk, bus.tc, bus.div_ack, bus.div_err};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset: got cnt/fb/tc/ack/err=%h expected %h", obs(), 12'h000);
    end
    rst = 1'b0;
  endtask

  task automatic test_default_ratio();
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (obs() !== ev(k % 4, 4, 0, 0)) begin
        n_fail++;
        $display("FAIL default_n4 k=%0d: got %h expected %h", k, obs(), ev(k % 4, 4, 0, 0));
      end
    end
  endtask

  task automatic test_invalid_load();
    bus.div_n = 8'd0; bus.div_load = 1'b1;
    tick();
    n_checks++;
    if (obs() !== ev(1, 4, 0, 1)) begin
      n_fail++;
      $display("FAIL err_n0: got %h expected %h", obs(), ev(1, 4, 0, 1));
    end
    bus.div_n = 8'd1;
    tick();
    n_checks++;
    if (obs() !== ev(2, 4, 0, 1)) begin
      n_fail++;
      $display("FAIL err_n1: got %h expected %h", obs(), ev(2, 4, 0, 1));
    end
    bus.div_load = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      tick();
      n_checks++;
      if (obs() !== ev(k % 4, 4, 0, 0)) begin
        n_fail++;
        $display("FAIL err_keep_n4 k=%0d: got %h expected %h", k, obs(), ev(k % 4, 4, 0, 0));
      end
    end
  endtask

  task automatic test_load_odd();
    tick();
    n_checks++;
    if (obs() !== ev(1, 4, 0, 0)) begin
      n_fail++;
      $display("FAIL n5_pre: got %h expected %h", obs(), ev(1, 4, 0, 0));
    end
    bus.div_n = 8'd5; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      n_checks++;
      if (obs() !== ev(k, 4, 0, 0)) begin
        n_fail++;
        $display("FAIL n5_wait k=%0d: got %h expected %h", k, obs(), ev(k, 4, 0, 0));
      end
      tick();
    end
    n_checks++;
    if (obs() !== ev(0, 5, 1, 0)) begin
      n_fail++;
      $display("FAIL n5_ack: got %h expected %h", obs(), ev(0, 5, 1, 0));
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (obs() !== ev(k % 5, 5, 0, 0)) begin
        n_fail++;
        $display("FAIL n5_run k=%0d: got %h expected %h", k, obs(), ev(k % 5, 5, 0, 0));
      end
    end
  endtask

  task automatic test_last_load_wins();
    bus.div_n = 8'd6; bus.div_load = 1'b1;
    tick();
    bus.div_n = 8'd8;
    n_checks++;
    if (obs() !== ev(1, 5, 0, 0)) begin
      n_fail++;
      $display("FAIL n8_load6: got %h expected %h", obs(), ev(1, 5, 0, 0));
    end
    tick();
    bus.div_load = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      n_checks++;
      if (obs() !== ev(k, 5, 0, 0)) begin
        n_fail++;
        $display("FAIL n8_wait k=%0d: got %h expected %h", k, obs(), ev(k, 5, 0, 0));
      end
      tick();
    end
    n_checks++;
    if (obs() !== ev(0, 8, 1, 0)) begin
      n_fail++;
      $display("FAIL n8_ack: got %h expected %h", obs(), ev(0, 8, 1, 0));
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_checks++;
      if (obs() !== ev(k % 8, 8, 0, 0)) begin
        n_fail++;
        $display("FAIL n8_run k=%0d: got %h expected %h", k, obs(), ev(k % 8, 8, 0, 0));
      end
    end
  endtask

  task automatic test_load_in_wrap();
    bus.div_n = 8'd7; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      n_checks++;
      if (obs() !== ev(k, 8, 0, 0)) begin
        n_fail++;
        $display("FAIL n7_wait k=%0d: got %h expected %h", k, obs(), ev(k, 8, 0, 0));
      end
      if (k < 7) tick();
    end
    bus.div_n = 8'd2; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    n_checks++;
    if (obs() !== ev(0, 7, 1, 0)) begin
      n_fail++;
      $display("FAIL n7_ack: got %h expected %h", obs(), ev(0, 7, 1, 0));
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (obs() !== ev(k, 7, 0, 0)) begin
        n_fail++;
        $display("FAIL n7_run k=%0d: got %h expected %h", k, obs(), ev(k, 7, 0, 0));
      end
    end
    tick();
    n_checks++;
    if (obs() !== ev(0, 2, 1, 0)) begin
      n_fail++;
      $display("FAIL n2_ack: got %h expected %h", obs(), ev(0, 2, 1, 0));
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (obs() !== ev(k % 2, 2, 0, 0)) begin
        n_fail++;
        $display("FAIL n2_run k=%0d: got %h expected %h", k, obs(), ev(k % 2, 2, 0, 0));
      end
    end
  endtask

  task automatic test_rst_with_pending();
    bus.div_n = 8'd10; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    n_checks++;
    if (obs() !== ev(1, 2, 0, 0)) begin
      n_fail++;
      $display("FAIL rst_pre: got %h expected %h", obs(), ev(1, 2, 0, 0));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs() !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_mid: got %h expected %h", obs(), 12'h000);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (obs() !== ev(k % 4, 4, 0, 0)) begin
        n_fail++;
        $display("FAIL rst_n4 k=%0d: got %h expected %h", k, obs(), ev(k % 4, 4, 0, 0));
      end
    end
  endtask

  initial begin
    bus.div_n    = '0;
    bus.div_load = 1'b0;
    test_reset();
    test_default_ratio();
    test_invalid_load();
    test_load_odd();
    test_last_load_wins();
    test_load_in_wrap();
    test_rst_with_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
